// File: rtl/ldseq.sv
// ldseq: load sequencer issuing one-hot bank load strobes, immediately or deferred to the next frame event.
// Define LDSEQ_PEND_EN to add a one-entry pending buffer behind the staging register.
module ldseq (
    input  logic        clk,
    input  logic        resetl,
    input  logic        wr_req,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        wr_defer,
    output logic        wr_rdy,
    input  logic        frame,
    output logic [7:0]  ld,
    output logic [15:0] ld_d,
    output logic        busy,
    output logic        pend
);
    typedef enum logic [1:0] {IDLE, WAIT, LOAD} state_t;
    state_t      state, nxt_state;
    logic [2:0]  stg_addr, nxt_addr;
    logic [15:0] stg_data, nxt_data;
    logic        frame_q;
    logic        accept;
    logic        frame_ev;
    assign accept   = wr_req & wr_rdy;
    // a frame held high for several cycles counts as one event
    assign frame_ev = frame & ~frame_q;
    assign busy     = state != IDLE;
    assign ld       = (state == LOAD) ? 8'd1 << stg_addr : 8'd0;
`ifdef LDSEQ_PEND_EN
    logic        pend_q, nxt_pend;
    logic [2:0]  p_addr, nxt_p_addr;
    logic [15:0] p_data, nxt_p_data;
    logic        p_defer, nxt_p_defer;
    assign pend   = pend_q;
    assign wr_rdy = (state == IDLE) | ~pend_q;
`else
    assign pend   = 1'b0;
    assign wr_rdy = state == IDLE;
`endif
    always_comb begin
        nxt_state = state;
        nxt_addr  = stg_addr;
        nxt_data  = stg_data;
`ifdef LDSEQ_PEND_EN
        nxt_pend    = pend_q;
        nxt_p_addr  = p_addr;
        nxt_p_data  = p_data;
        nxt_p_defer = p_defer;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    nxt_addr  = wr_addr;
                    nxt_data  = wr_data;
                    nxt_state = wr_defer ? WAIT : LOAD;
                end
            end
            WAIT: begin
                if (frame_ev) nxt_state = LOAD;
`ifdef LDSEQ_PEND_EN
                if (accept) begin
                    nxt_pend    = 1'b1;
                    nxt_p_addr  = wr_addr;
                    nxt_p_data  = wr_data;
                    nxt_p_defer = wr_defer;
                end
`endif
            end
            LOAD: begin
                nxt_state = IDLE;
`ifdef LDSEQ_PEND_EN
                // staging frees this edge, so the next write follows with no idle gap
                if (pend_q) begin
                    nxt_addr  = p_addr;
                    nxt_data  = p_data;
                    nxt_state = p_defer ? WAIT : LOAD;
                    nxt_pend  = 1'b0;
                end else if (accept) begin
                    nxt_addr  = wr_addr;
                    nxt_data  = wr_data;
                    nxt_state = wr_defer ? WAIT : LOAD;
                end
`endif
            end
            default: nxt_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state    <= IDLE;
            stg_addr <= 3'd0;
            stg_data <= 16'd0;
            ld_d     <= 16'd0;
            frame_q  <= 1'b0;
        end else begin
            state    <= nxt_state;
            stg_addr <= nxt_addr;
            stg_data <= nxt_data;
            frame_q  <= frame;
            if (nxt_state == LOAD) ld_d <= nxt_data;
        end
    end
`ifdef LDSEQ_PEND_EN
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            pend_q  <= 1'b0;
            p_addr  <= 3'd0;
            p_data  <= 16'd0;
            p_defer <= 1'b0;
        end else begin
            pend_q  <= nxt_pend;
            p_addr  <= nxt_p_addr;
            p_data  <= nxt_p_data;
            p_defer <= nxt_p_defer;
        end
    end
`endif
endmodule
